prog_loader: RTL and testbench
==============================

# prog_loader

Program loader for the 4-bit microprocessor: the writer side of the instruction ROM that the core reads. It accepts a framed word stream (length, instruction words, checksum) over a valid/ready handshake and writes each word into instruction memory. It holds the core in reset until a complete, checksum-correct program is in memory. It sits between the host/bench stimulus port and the `top` instruction memory write port.

## Interface

Parameters:
- BIT_WIDTH, 4, datapath/operand width of the core
- ADDR_WIDTH, 4, instruction memory address width; depth = 2^ADDR_WIDTH
- INSTR_WIDTH, 8, instruction word width (opcode + operand); also the stream word width

Ports (clk first):
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- in_data  input  INSTR_WIDTH  stream word
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a word this cycle
- reload  input  1  single-cycle pulse; restart framing
- mem_we  output  1  instruction memory write strobe
- mem_addr  output  ADDR_WIDTH  write address
- mem_wdata  output  INSTR_WIDTH  write data
- cpu_hold  output  1  high: core must be held in reset
- done  output  1  program loaded, checksum good
- err  output  1  frame rejected

## Operation

- Transfer occurs on a rising edge with in_valid & in_ready both high.
- Frame: word 0 = length L; words 1..L = instructions, written to addresses 0..L-1; final word = checksum C.
- L = 0 means full depth (2^ADDR_WIDTH). L > 2^ADDR_WIDTH means ERROR immediately after the length word; no memory writes occur.
- Checksum: a mod-2^INSTR_WIDTH sum of L, all instruction words, and C. A sum of 0 means good.
- States:
  - IDLE → LEN unconditionally.
  - LEN → DATA on a valid L, or → ERROR on an oversized L.
  - DATA → CHECK after the L-th word.
  - CHECK → DONE (sum = 0) or ERROR (sum ≠ 0).
  - DONE/ERROR hold until reload.
- in_ready is high only in LEN, DATA, and CHECK.
- reload in any state → LEN next edge. This clears the accumulator, word count, done, and err. cpu_hold = 1.
- reload coincident with a transfer: reload wins and the word is discarded. Memory writes already issued are not undone.
- cpu_hold is 0 only in DONE. done = (state == DONE). err = (state == ERROR).
- Word counter is ADDR_WIDTH+1 bits so that a full-depth load terminates correctly.

## Timing

- Reset values (asynchronous, while rst = 0):
  - state IDLE
  - in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0
  - cpu_hold 1, done 0, err 0
- First in_ready = 1 appears two edges after rst deasserts (IDLE → LEN, then registered ready).
- All outputs are registered.
- An instruction transfer at edge k gives mem_we = 1 with its addr/data during cycle k+1, for exactly one cycle.
- Checksum transfer at edge k: done/err/cpu_hold update at edge k+1, and in_ready drops at edge k+1.
  - in_ready may still be high in cycle k+1 due to registration. It must not be: in_ready is decoded from next-state so it is 0 in cycle k+1.
- Back-to-back transfers are sustained at one word per cycle. A gap (in_valid = 0) stalls with no state change.
- rst asserted mid-frame forces reset values immediately. The partial program is abandoned and cpu_hold goes to 1.

## Structure

- Package `loader_pkg`: state enum (IDLE, LEN, DATA, CHECK, DONE, ERROR) and the depth constant derived from ADDR_WIDTH.
- Sub-module `prog_checksum`: INSTR_WIDTH accumulator with clear, add-enable, and zero-flag. It uses the same clk/rst.
- FSM, counter, and write-port registers live in `prog_loader`.

## Test plan

- Fibonacci load: L = 3, words 0x11, 0x22, 0x33, C = 0x97 (sum 0x00).
  - Expect writes at addresses 0/1/2 with those data, one cycle after each transfer.
  - Then done = 1 and cpu_hold = 0 one cycle after C.
- Bad checksum: same frame with C = 0x96.
  - Expect err = 1, done = 0, cpu_hold = 1, in_ready = 0.
  - reload then restarts: in_ready = 1 and err = 0 next cycle.
- Oversized length: L = 17 with ADDR_WIDTH = 4.
  - Expect err = 1 after one transfer and no mem_we pulses.
- Full depth: L = 0, 16 words 0x00..0x0F, C = 0x88.
  - Expect addresses 0..15 written and done = 1. The counter must not wrap early.
- Stall and abort:
  - in_valid toggles 1,0,1 mid-DATA: the write count matches the accepted words only.
  - reload coincident with the 2nd instruction transfer: that word is not written and the state is LEN.
- Async reset mid-DATA: rst low between edges.
  - Expect outputs at reset values before the next edge.
  - After release, in_ready = 1 at the 2nd edge.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
// Contents:
//   state_e          - loader FSM states
//   depth_for()      - instruction memory depth for a given address width
//   accepts_words()  - true for the states in which the loader takes stream words
//   LOADER_DEPTH     - default memory depth (ADDR_WIDTH = 4)
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    localparam int unsigned LOADER_ADDR_WIDTH = 32'd4;

    function automatic int unsigned depth_for(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned LOADER_DEPTH = depth_for(LOADER_ADDR_WIDTH);

    function automatic logic accepts_words(input state_e s);
        logic r;
        case (s)
            ST_LEN, ST_DATA, ST_CHECK: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/prog_checksum.sv
// Running modular checksum for the loader frame.
// Ports:
//   clk, rst    - clock and asynchronous active-low reset
//   clr_i       - zero the accumulator (wins over add_i)
//   add_i       - accumulate data_i this cycle
//   data_i      - word being accepted
//   sum_zero_o  - accumulator + data_i is zero; lets the loader judge the
//                 checksum word in the same cycle it is accepted
module prog_checksum #(
    parameter int unsigned INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   add_i,
    input  logic [INSTR_WIDTH-1:0] data_i,
    output logic                   sum_zero_o
);

    logic [INSTR_WIDTH-1:0] acc_q;
    logic [INSTR_WIDTH-1:0] acc_d;
    logic [INSTR_WIDTH-1:0] sum_s;

    assign sum_s      = acc_q + data_i;
    assign sum_zero_o = (sum_s == '0);

    // Next accumulator value: clear, add or hold.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a framed word stream (length, instructions,
// checksum) and writes the instructions into the core's instruction memory,
// holding the core in reset until a checksum-correct program is loaded.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   in_data/in_valid/in_ready - stream input handshake
//   reload                    - one-cycle pulse, restart framing
//   mem_we/mem_addr/mem_wdata - instruction memory write port
//   cpu_hold                  - high while the core must stay in reset
//   done / err                - frame accepted / frame rejected
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   reload,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned DEPTH = depth_for(ADDR_WIDTH);
    // One extra bit so a full-depth count (DEPTH) is representable.
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // An instruction must at least hold one operand of the datapath.
    if (BIT_WIDTH > INSTR_WIDTH) begin : g_bad_width
        $error("prog_loader: BIT_WIDTH exceeds INSTR_WIDTH");
    end

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          len_q, len_d;
    logic                   in_ready_q, in_ready_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                   cpu_hold_q, done_q, err_q;
    logic                   xfer_s;
    logic                   csum_clr_s, csum_add_s, csum_zero_s;

    // in_ready_q is only ever high in LEN/DATA/CHECK, so this is a real transfer.
    assign xfer_s = in_valid & in_ready_q;

    prog_checksum #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_csum (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (csum_clr_s),
        .add_i      (csum_add_s),
        .data_i     (in_data),
        .sum_zero_o (csum_zero_s)
    );

    // Frame FSM, word counter and write-port next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        csum_clr_s  = 1'b0;
        csum_add_s  = 1'b0;
        if (reload) begin
            // Reload beats a coincident transfer; that word is dropped.
            state_d    = ST_LEN;
            cnt_d      = '0;
            len_d      = '0;
            csum_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_LEN;
                    csum_clr_s = 1'b1;
                end
                ST_LEN: begin
                    if (xfer_s) begin
                        csum_add_s = 1'b1;
                        cnt_d      = '0;
                        if (32'(in_data) > DEPTH) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_DATA;
                            // Length 0 encodes a full-depth program.
                            len_d   = (in_data == '0) ? DEPTH_C : CW'(in_data);
                        end
                    end else begin
                        state_d = ST_LEN;
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        csum_add_s  = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = in_data;
                        cnt_d       = cnt_q + ONE_C;
                        if (cnt_d == len_q) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_CHECK: begin
                    if (xfer_s) begin
                        csum_add_s = 1'b1;
                        if (csum_zero_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Ready follows the next state so it drops in the same edge the frame
    // ends; the IDLE exclusion gives the one-cycle delay after reset.
    always_comb begin
        in_ready_d = 1'b0;
        if (state_q == ST_IDLE) begin
            in_ready_d = 1'b0;
        end else begin
            in_ready_d = accepts_words(state_d);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= (state_d != ST_DONE);
            done_q      <= (state_d == ST_DONE);
            err_q       <= (state_d == ST_ERROR);
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan
// plus randomized frames, judged against a frame-level reference model.
module tb_prog_loader;

    localparam int AW    = 4;
    localparam int IW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          reload = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int frame_q[$];

    always #5 clk = ~clk;

    prog_loader #(
        .BIT_WIDTH   (4),
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    // Count write strobes seen by the memory.
    always @(negedge clk) begin
        if (mem_we === 1'b1) we_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   32'(in_ready),  32'd0);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_hold"},  32'(cpu_hold),  32'd1);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_err"},   32'(err),       32'd0);
    endtask

    // Offer one word until accepted; returns at the negedge after the transfer.
    task automatic send_word(input int w, input bit stall);
        bit ok;
        int n;
        if (stall) begin
            in_valid = 1'b0;
            in_data  = IW'($urandom);
            tick();
            chk("stall_we", 32'(mem_we), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = IW'(w);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            ok = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_rdy",  32'(in_ready), 32'd1);
        chk("reload_err",  32'(err),      32'd0);
        chk("reload_done", 32'(done),     32'd0);
        chk("reload_hold", 32'(cpu_hold), 32'd1);
    endtask

    // Build length, instructions (sequential or random) and checksum.
    task automatic build(input int len, input bit good, input bit seq);
        int lf, sum, c;
        frame_q.delete();
        frame_q.push_back(len);
        if (len <= DEPTH) begin
            lf  = (len == 0) ? DEPTH : len;
            sum = len;
            for (int i = 0; i < lf; i++) begin
                frame_q.push_back(seq ? i : int'($urandom_range(0, 255)));
                sum += frame_q[i + 1];
            end
            c = (256 - (sum % 256)) % 256;
            if (!good) c = (c + int'($urandom_range(1, 255))) % 256;
            frame_q.push_back(c);
        end
    endtask

    // Send frame_q and compare against the frame-level model.
    task automatic run_frame(input int stall_pct);
        int  len, lf, sum, base;
        bit  good;
        len  = frame_q[0];
        base = we_cnt;
        send_word(len, int'($urandom_range(0, 99)) < stall_pct);
        if (len > DEPTH) begin
            chk("over_err",  32'(err),      32'd1);
            chk("over_rdy",  32'(in_ready), 32'd0);
            chk("over_hold", 32'(cpu_hold), 32'd1);
            chk("over_we",   32'(mem_we),   32'd0);
            lf = 0;
        end else begin
            lf  = (len == 0) ? DEPTH : len;
            sum = 0;
            foreach (frame_q[i]) sum += frame_q[i];
            good = ((sum % 256) == 0);
            chk("len_we", 32'(mem_we), 32'd0);
            for (int i = 1; i <= lf; i++) begin
                send_word(frame_q[i], int'($urandom_range(0, 99)) < stall_pct);
                chk("wr_we",    32'(mem_we),    32'd1);
                chk("wr_addr",  32'(mem_addr),  32'(i - 1));
                chk("wr_wdata", 32'(mem_wdata), 32'(frame_q[i]));
            end
            send_word(frame_q[lf + 1], int'($urandom_range(0, 99)) < stall_pct);
            chk("end_done", 32'(done),     32'(good));
            chk("end_err",  32'(err),      32'(!good));
            chk("end_hold", 32'(cpu_hold), 32'(!good));
            chk("end_rdy",  32'(in_ready), 32'd0);
            chk("end_we",   32'(mem_we),   32'd0);
        end
        #1;
        chk("we_count", 32'(we_cnt - base), 32'(lf));
    endtask

    initial begin
        // Asynchronous reset and the two-edge ready delay.
        #2 rst = 1'b0;
        #1 chk_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst_hold");
        rst = 1'b1;
        tick();
        chk("rdy_edge1", 32'(in_ready), 32'd0);
        tick();
        chk("rdy_edge2", 32'(in_ready), 32'd1);

        // Fibonacci load.
        frame_q = '{3, 8'h11, 8'h22, 8'h33, 8'h97};
        run_frame(0);
        do_reload();

        // Bad checksum.
        frame_q = '{3, 8'h11, 8'h22, 8'h33, 8'h96};
        run_frame(0);
        do_reload();

        // Oversized length.
        frame_q = '{17};
        run_frame(0);
        do_reload();

        // Full depth, checksum 0x88.
        build(0, 1'b1, 1'b1);
        chk("full_csum", 32'(frame_q[17]), 32'h88);
        run_frame(0);
        do_reload();

        // Stalls mid-frame.
        frame_q = '{3, 8'h11, 8'h22, 8'h33, 8'h97};
        run_frame(60);
        do_reload();

        // Reload coincident with the second instruction transfer.
        send_word(3, 1'b0);
        send_word(8'h11, 1'b0);
        chk("abort_w1", 32'(mem_we), 32'd1);
        chk("abort_rdy_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h22;
        reload   = 1'b1;
        tick();
        reload   = 1'b0;
        in_valid = 1'b0;
        chk("abort_we",  32'(mem_we),   32'd0);
        chk("abort_rdy", 32'(in_ready), 32'd1);
        chk("abort_err", 32'(err),      32'd0);
        frame_q = '{3, 8'h11, 8'h22, 8'h33, 8'h97};
        run_frame(0);
        do_reload();

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            int len;
            len = int'($urandom_range(0, 18));
            if ($urandom_range(0, 9) == 0) len = int'($urandom_range(19, 255));
            build(len, $urandom_range(0, 3) != 0, 1'b0);
            run_frame(25);
            do_reload();
        end

        // Asynchronous reset in the middle of DATA.
        build(5, 1'b1, 1'b0);
        send_word(frame_q[0], 1'b0);
        send_word(frame_q[1], 1'b0);
        send_word(frame_q[2], 1'b0);
        #2 rst = 1'b0;
        #1 chk_reset_vals("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("mid_rdy_edge1", 32'(in_ready), 32'd0);
        tick();
        chk("mid_rdy_edge2", 32'(in_ready), 32'd1);
        frame_q = '{3, 8'h11, 8'h22, 8'h33, 8'h97};
        run_frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
